// File: rtl/leakyrelu_backward.sv
// Leaky-ReLU backward pass: per-sample sign FIFO filled during the forward pass, and a
// gradient pipeline scaling by ALPHA where the recorded sign was negative.
// Optional macro LRELU_SIGN_BYPASS_EN: use i_fwd_data's sign directly when the FIFO is empty.

module multiplier_floating_point32 #(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] res
);

    // Single-precision multiply, round-to-nearest-even; subnormal inputs/results flush to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [47:0] prod;
        logic [9:0]  exp_u;
        logic [22:0] frac;
        logic        guard;
        logic        sticky;
        logic        inc;
        logic [30:0] mag;
        sgn    = a[31] ^ b[31];
        prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        exp_u  = 10'(a[30:23]) + 10'(b[30:23]) + 10'(prod[47]);
        frac   = prod[47] ? prod[46:24] : prod[45:23];
        guard  = prod[47] ? prod[23] : prod[22];
        sticky = prod[47] ? (|prod[22:0]) : (|prod[21:0]);
        inc    = guard & (sticky | frac[0]);
        mag    = {8'(exp_u - 10'd127), frac} + 31'(inc);
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
                a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
                fp_mul = 32'h7FC00000;
            end else begin
                fp_mul = {sgn, 8'hFF, 23'd0};
            end
        end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || exp_u <= 10'd127) begin
            fp_mul = {sgn, 31'd0};
        end else if (exp_u >= 10'd382) begin
            fp_mul = {sgn, 8'hFF, 23'd0};
        end else begin
            fp_mul = {sgn, mag};
        end
    endfunction

    logic [31:0] pipe_r [LATENCY];

    // Product pipeline, LATENCY register stages.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_r[i] <= 32'd0;
            end
        end else begin
            pipe_r[0] <= fp_mul(in_a, in_b);
            for (int i = 1; i < LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign res = pipe_r[LATENCY-1];

endmodule

module leakyrelu_backward #(
    parameter int              DATA_WIDTH  = 32,
    parameter logic [31:0]     ALPHA       = 32'h3DCCCCCD,
    parameter int              DEPTH       = 64,
    parameter int              MUL_LATENCY = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_fwd_valid,
    input  logic [DATA_WIDTH-1:0]    i_fwd_data,
    input  logic                     i_grad_valid,
    input  logic [DATA_WIDTH-1:0]    i_grad,
    output logic [DATA_WIDTH-1:0]    o_grad,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]      sign_mem_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  ovf_r;
    logic                  unf_r;

    logic                  bypass_s;
    logic                  rd_en_s;
    logic                  wr_en_s;
    logic                  drop_s;
    logic                  under_s;
    logic                  entry_sign_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [DATA_WIDTH-1:0] mul_res_s;
    logic                  unused_fwd_bits_s;

    logic                  dl_valid_r [MUL_LATENCY];
    logic                  dl_sign_r  [MUL_LATENCY];
    logic [DATA_WIDTH-1:0] dl_grad_r  [MUL_LATENCY];

    // Only the sign of the forward value matters.
    assign unused_fwd_bits_s = ^i_fwd_data[DATA_WIDTH-2:0];

    // FIFO handshake decode and the sign attached to an incoming gradient.
    always_comb begin
        bypass_s     = 1'b0;
        entry_sign_s = 1'b0;
        count_nxt_s  = count_r;
`ifdef LRELU_SIGN_BYPASS_EN
        bypass_s     = empty_r && i_fwd_valid && i_grad_valid;
`endif
        rd_en_s = i_grad_valid && !empty_r;
        wr_en_s = i_fwd_valid && !bypass_s && (!full_r || rd_en_s);
        drop_s  = i_fwd_valid && full_r && !rd_en_s;
        under_s = i_grad_valid && empty_r && !bypass_s;
        if (rd_en_s) begin
            entry_sign_s = sign_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            entry_sign_s = i_fwd_data[DATA_WIDTH-1];
        end else begin
            entry_sign_s = 1'b0;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and sticky error flags; flush clears them like reset.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r <= (count_nxt_s == CNT_W'(0));
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
            if (under_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    // Sign storage; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst && !i_flush) begin
            sign_mem_r[wr_ptr_r] <= i_fwd_data[DATA_WIDTH-1];
        end
    end

    multiplier_floating_point32 #(
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk  (clk),
        .rstn (~rst),
        .in_a (i_grad),
        .in_b (ALPHA),
        .res  (mul_res_s)
    );

    // Delay line matching the multiplier latency; flush leaves in-flight gradients alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                dl_valid_r[i] <= 1'b0;
                dl_sign_r[i]  <= 1'b0;
                dl_grad_r[i]  <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            dl_valid_r[0] <= i_grad_valid;
            dl_sign_r[0]  <= entry_sign_s;
            dl_grad_r[0]  <= i_grad;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                dl_valid_r[i] <= dl_valid_r[i-1];
                dl_sign_r[i]  <= dl_sign_r[i-1];
                dl_grad_r[i]  <= dl_grad_r[i-1];
            end
        end
    end

    // Output stage: select scaled or raw gradient, zero when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_grad  <= {DATA_WIDTH{1'b0}};
        end else if (dl_valid_r[MUL_LATENCY-1]) begin
            o_valid <= 1'b1;
            o_grad  <= dl_sign_r[MUL_LATENCY-1] ? mul_res_s : dl_grad_r[MUL_LATENCY-1];
        end else begin
            o_valid <= 1'b0;
            o_grad  <= {DATA_WIDTH{1'b0}};
        end
    end

    assign o_count     = count_r;
    assign o_full      = full_r;
    assign o_empty     = empty_r;
    assign o_overflow  = ovf_r;
    assign o_underflow = unf_r;

endmodule

// File: doc/leakyrelu_backward.md
Name: leakyrelu_backward

Overview:
- Backward-pass companion to the forward leaky-ReLU activation in the DQN datapath.
- During the forward pass it records the sign of each pre-activation value in a FIFO.
- During backprop it consumes one recorded sign per incoming gradient.
  - Negative recorded sign: outputs gradient*ALPHA.
  - Otherwise: outputs the gradient unchanged.
- Sits between the layer's error-propagation stage and the weight-update multiplier chain.

Parameters:
- DATA_WIDTH, 32, float word width (IEEE-754 single).
- ALPHA, 32'h3DCCCCCD, leak slope (0.1); must equal the forward block's ALPHA.
- DEPTH, 64, sign FIFO entries (power of two).
- MUL_LATENCY, 7, latency of multiplier_floating_point32.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_flush  in  1  synchronous clear of FIFO and error flags (episode boundary)
- i_fwd_valid  in  1  forward pre-activation sample present
- i_fwd_data  in  DATA_WIDTH  forward pre-activation value; only bit DATA_WIDTH-1 is used
- i_grad_valid  in  1  upstream gradient present
- i_grad  in  DATA_WIDTH  upstream gradient
- o_grad  out  DATA_WIDTH  downstream gradient
- o_valid  out  1  o_grad valid
- o_full  out  1  sign FIFO full
- o_empty  out  1  sign FIFO empty
- o_count  out  $clog2(DEPTH)+1  stored sign count
- o_overflow  out  1  sticky: forward sample dropped
- o_underflow  out  1  sticky: gradient arrived with no stored sign

Behaviour:
- Reset (rst=1 at posedge) clears everything.
  - Outputs: o_grad=0, o_valid=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0.
  - FIFO pointers zeroed; delay-line valids cleared.
  - Internal multiplier gets rstn = ~rst.
- i_flush (rst has priority):
  - Zeroes FIFO pointers/count and both sticky flags.
  - In-flight gradients in the pipeline still complete normally.
- Sign FIFO:
  - Write when i_fwd_valid and (!full or read this cycle).
  - A write to a full FIFO with no simultaneous read is dropped and sets o_overflow.
  - Read when i_grad_valid and !empty.
  - Simultaneous read+write: count unchanged, pointers wrap modulo DEPTH.
  - o_full/o_empty/o_count are registered and reflect state after the current edge.
- Gradient pipeline:
  - Every i_grad_valid cycle feeds i_grad to the multiplier with inB=ALPHA.
  - In parallel, a MUL_LATENCY-deep shift register carries {valid, sign, raw grad}.
  - The popped sign is attached at entry. On underflow (FIFO empty) sign=0, the gradient passes unchanged, and o_underflow is set.
  - Output stage registered: o_grad = sign ? mul_out : raw grad; o_valid = delayed valid.
  - Latency: i_grad_valid at cycle N gives o_valid at cycle N+MUL_LATENCY+1. Throughput 1/cycle, no stalls.
  - When o_valid=0, o_grad=0 (never high-Z).
  - Sign-bit-only test: -0.0 counts as negative; +0.0 counts as positive.
- Without bypass: a write and read in the same cycle on an empty FIFO is an underflow; the written sign is stored.

Optional Feature:
- Macro: LRELU_SIGN_BYPASS_EN.
- Defined: when the FIFO is empty and i_fwd_valid and i_grad_valid coincide, i_fwd_data's sign is used directly for that gradient. It is not stored, count stays 0, and no underflow is flagged.
- Undefined: behaviour as above (underflow, sign stored).

Test Plan:
- Write fwd 0xC0000000 (-2.0), then grad 0x3F800000 (1.0) → o_valid 8 cycles later, o_grad=0x3DCCCCCD; o_empty=1.
- Write fwd 0x40400000 (+3.0), then grad 0x40000000 → o_grad=0x40000000 after 8 cycles, bit-exact pass-through.
- Write 64 alternating signs (+,-), then 64 back-to-back grads of 0x3F800000 → outputs alternate 0x3F800000/0x3DCCCCCD in order, one per cycle; o_full 1→0, o_count 64→0.
- 65th write when full with no read → o_overflow=1, count stays 64. Then write+read same cycle while full → count stays 64, no new overflow.
- Grad 0x3F800000 with FIFO empty → o_grad=0x3F800000, o_underflow=1; i_flush → o_underflow=0, o_count=0.
- rst asserted mid-stream with 3 gradients in flight → next cycle o_valid=0, o_grad=0, o_count=0, no stale outputs after release.
